// File: rtl/multi_rate_blink_ctrl.sv
// Multi-rate LED blink controller: prescaled timebase, 3-bit rate divider,
// config latched on rate ticks, OFF/SOLID/BLINK/CHASE pattern decode.
module multi_rate_blink_ctrl #(
  parameter int NUM_LEDS = 4,
  parameter int COUNT    = 12500000,
  localparam int SEL_W   = ($clog2(NUM_LEDS) < 1) ? 1 : $clog2(NUM_LEDS)
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Enable,
  input  logic [SEL_W-1:0]    i_Sel,
  input  logic [1:0]          i_Mode,
  input  logic [1:0]          i_Rate,
  output logic [NUM_LEDS-1:0] o_LED,
  output logic                o_Tick
);

  localparam int CNT_W = ($clog2(COUNT) < 1) ? 1 : $clog2(COUNT);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_SOLID = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_CHASE = 2'b11;

  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       div_q, div_d;
  logic             phase_q, phase_d;
  logic [SEL_W-1:0] pos_q, pos_d;
  logic [1:0]       mode_q, mode_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [1:0]       rate_q, rate_d;
  logic             tick_q, tick_d;

  logic             base_tick;
  logic             rate_tick;
  logic [2:0]       rate_mask;
  logic [NUM_LEDS-1:0] sel_hot;
  logic [NUM_LEDS-1:0] pos_hot;

  always_comb begin
    unique case (rate_q)
      2'd0:    rate_mask = 3'b000;
      2'd1:    rate_mask = 3'b001;
      2'd2:    rate_mask = 3'b011;
      default: rate_mask = 3'b111;
    endcase
    base_tick = i_Enable && (count_q == CNT_W'(COUNT - 1));
    rate_tick = base_tick && ((div_q & rate_mask) == rate_mask);
  end

  always_comb begin
    count_d = count_q;
    div_d   = div_q;
    phase_d = phase_q;
    pos_d   = pos_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    rate_d  = rate_q;
    tick_d  = rate_tick;
    if (i_Enable) begin
      count_d = base_tick ? '0 : count_q + CNT_W'(1);
    end
    if (base_tick) begin
      div_d = div_q + 3'd1;
    end
    if (rate_tick) begin
      mode_d  = i_Mode;
      sel_d   = i_Sel;
      rate_d  = i_Rate;
      phase_d = ~phase_q;
      pos_d   = '0;
      if (mode_q == MODE_CHASE && i_Mode == MODE_CHASE) begin
        pos_d = (pos_q == SEL_W'(NUM_LEDS - 1)) ? '0 : pos_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count_q <= '0;
      div_q   <= '0;
      phase_q <= 1'b0;
      pos_q   <= '0;
      mode_q  <= MODE_OFF;
      sel_q   <= '0;
      rate_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      rate_q  <= rate_d;
      tick_q  <= tick_d;
    end
  end

  // Shifting past the top bit yields zero, which blanks out-of-range selects.
  always_comb begin
    sel_hot = NUM_LEDS'(1) << sel_q;
    pos_hot = NUM_LEDS'(1) << pos_q;
    o_LED   = '0;
    unique case (mode_q)
      MODE_OFF:   o_LED = '0;
      MODE_SOLID: o_LED = sel_hot;
      MODE_BLINK: o_LED = phase_q ? sel_hot : '0;
      default:    o_LED = pos_hot;
    endcase
  end

  assign o_Tick = tick_q & i_Enable;

endmodule
